key_matrix_scan: RTL and testbench

- Keypad front end that produces the 10-bit `keynote` vector consumed by the note/pitch display counter.
- Drives a 4-column by 3-row active-low key matrix one column at a time, paced by an external scan strobe, in the same style as the display digit multiplexing.
- Debounces the scanned frames and outputs a stable key-state vector plus a one-cycle new-press event.

---
 rtl/key_matrix_scan_if.sv | 25 ++
 rtl/key_matrix_scan.sv | 95 +++++++++
 tb/tb_key_matrix_scan.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_matrix_scan_if.sv
// Scan-side and key-state signals of the keypad front end, bundled for the
// matrix scanner (slave) and whatever drives the strobe and reads the keys (master).
interface key_matrix_scan_if;
  logic       scan_tick;
  logic [2:0] row_n;
  logic [3:0] col_sel_n;
  logic [9:0] keynote;
  logic       key_event;

  modport master (
    output scan_tick,
    output row_n,
    input  col_sel_n,
    input  keynote,
    input  key_event
  );

  modport slave (
    input  scan_tick,
    input  row_n,
    output col_sel_n,
    output keynote,
    output key_event
  );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x3 active-low keypad scanner with frame debounce producing the 10-bit keynote vector.
// Optional macro SINGLE_KEY_EN: commit only the lowest-indexed held key (one-hot).
module key_matrix_scan #(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned CNT_W           = 3
) (
  input logic              clk,
  input logic              rst,
  key_matrix_scan_if.slave bus
);
  localparam int unsigned ROWS = 3;
  localparam int unsigned KEYS = 10;

  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;
  logic [ROWS-1:0] row;
  logic [1:0]      col;
  logic [1:0]      col_next;
  logic [3:0]      col_sel_q;
  logic [8:0]      raw;
  logic [KEYS-1:0] cand;
  logic [KEYS-1:0] frame;
  logic [KEYS-1:0] commit_src;
  logic [KEYS-1:0] commit_val;
  logic [KEYS-1:0] keynote_q;
  logic [CNT_W-1:0] cnt;
  logic            key_event_q;
  logic            stable;

  // Row returns are asynchronous to clk; idle (no key) is all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= bus.row_n;
      row_sync <= row_meta;
    end
  end

  assign row = ~row_sync;

  // Column 3 rows 1..2 are never stored; only row 0 (key 9) joins the frame.
  always_comb begin
    col_next   = col + 2'd1;
    frame      = {row[0], raw};
    stable     = (frame == cand) && (cnt >= CNT_W'(DEBOUNCE_FRAMES - 1));
    commit_src = (DEBOUNCE_FRAMES == 1) ? frame : cand;
`ifdef SINGLE_KEY_EN
    commit_val = commit_src & (~commit_src + KEYS'(1));
`else
    commit_val = commit_src;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= 2'd0;
      col_sel_q   <= 4'b0111;
      raw         <= '0;
      cand        <= '0;
      cnt         <= '0;
      keynote_q   <= '0;
      key_event_q <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      if (bus.scan_tick) begin
        col       <= col_next;
        col_sel_q <= ~(4'b1000 >> col_next);
        case (col)
          2'd0: raw[2:0] <= row;
          2'd1: raw[5:3] <= row;
          2'd2: raw[8:6] <= row;
          default: begin
            // Frame end: debounce against the candidate, commit once it has held long enough.
            if (frame != cand) begin
              cand <= frame;
              cnt  <= '0;
            end else if (cnt < CNT_W'(DEBOUNCE_FRAMES - 1)) begin
              cnt <= cnt + CNT_W'(1);
            end
            if ((DEBOUNCE_FRAMES == 1) || stable) begin
              keynote_q   <= commit_val;
              key_event_q <= |(commit_val & ~keynote_q);
            end
          end
        endcase
      end
    end
  end

  assign bus.col_sel_n = col_sel_q;
  assign bus.keynote   = keynote_q;
  assign bus.key_event = key_event_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan: keypad model, frame-history debounce
// reference, directed scenarios and randomized key activity.
module tb_key_matrix_scan;
  localparam int DF = 3;

  logic clk;
  logic rst;
  logic [11:0] held;

  key_matrix_scan_if bus ();

  key_matrix_scan #(.DEBOUNCE_FRAMES(DF), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    bus.row_n = 3'b111;
    for (int c = 0; c < 4; c++)
      if (bus.col_sel_n[3-c] == 1'b0)
        for (int r = 0; r < 3; r++)
          if (held[c*3+r]) bus.row_n[r] = 1'b0;
  end

  int tests_run = 0;
  int fails = 0;
  int ev_seen = 0;

  int         m_col;
  logic [11:0] m_frame;
  logic [9:0] hist[$];
  logic [9:0] exp_keynote;
  logic       exp_event;
  logic [3:0] exp_sel;

  function automatic logic [9:0] lowest(input logic [9:0] v);
    for (int k = 0; k < 10; k++)
      if (v[k]) return 10'(1) << k;
    return 10'd0;
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_frame = '0;
    hist.delete();
    hist.push_back(10'd0);
    exp_keynote = '0;
    exp_event = 1'b0;
    exp_sel = 4'b0111;
  endtask

  // A press commits once DF+1 consecutive frames agree (reset counts as one all-zero frame).
  task automatic model_tick();
    logic [9:0] f;
    logic [9:0] v;
    logic       commit;
    m_frame[m_col*3 +: 3] = held[m_col*3 +: 3];
    exp_event = 1'b0;
    if (m_col == 3) begin
      f = m_frame[9:0];
      hist.push_back(f);
      while (hist.size() > DF + 1) void'(hist.pop_front());
      commit = (DF == 1);
      if (hist.size() == DF + 1) begin
        commit = 1'b1;
        foreach (hist[i]) if (hist[i] != f) commit = 1'b0;
      end
      if (commit) begin
`ifdef SINGLE_KEY_EN
        v = lowest(f);
`else
        v = f;
`endif
        exp_event = |(v & ~exp_keynote);
        exp_keynote = v;
      end
    end
    m_col = (m_col + 1) % 4;
    exp_sel = 4'b1111;
    exp_sel[3-m_col] = 1'b0;
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.key_event !== 1'b0) begin
        fails++;
        $display("FAIL idle_event got %b want 0 at %0t", bus.key_event, $time);
      end
      tests_run++;
      if ($countones(bus.col_sel_n) !== 3) begin
        fails++;
        $display("FAIL one_cold col_sel_n got %b at %0t", bus.col_sel_n, $time);
      end
    end
    bus.scan_tick = 1'b1;
    model_tick();
    @(negedge clk);
    bus.scan_tick = 1'b0;
    tests_run++;
    if (bus.col_sel_n !== exp_sel) begin
      fails++;
      $display("FAIL col_sel_n got %b want %b at %0t", bus.col_sel_n, exp_sel, $time);
    end
    tests_run++;
    if (bus.keynote !== exp_keynote) begin
      fails++;
      $display("FAIL keynote got %b want %b at %0t", bus.keynote, exp_keynote, $time);
    end
    tests_run++;
    if (bus.key_event !== exp_event) begin
      fails++;
      $display("FAIL key_event got %b want %b at %0t", bus.key_event, exp_event, $time);
    end
    if (bus.key_event === 1'b1) ev_seen++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < 4 * n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.scan_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ev_seen = 0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.col_sel_n !== 4'b0111 || bus.keynote !== 10'd0 || bus.key_event !== 1'b0) begin
      fails++;
      $display("FAIL reset_values got sel=%b key=%b ev=%b want 0111/0/0",
               bus.col_sel_n, bus.keynote, bus.key_event);
    end
    do_reset();
    held = 12'h202;
    frames(4);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.col_sel_n !== 4'b0111 || bus.keynote !== 10'd0 || bus.key_event !== 1'b0) begin
      fails++;
      $display("FAIL midscan_reset got sel=%b key=%b ev=%b want 0111/0/0",
               bus.col_sel_n, bus.keynote, bus.key_event);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ev_seen = 0;
    held = 12'h002;
    frames(4);
    tests_run++;
    if (bus.keynote !== 10'b0000000010) begin
      fails++;
      $display("FAIL after_reset_key got %b want 0000000010", bus.keynote);
    end
  endtask

  task automatic test_column_walk();
    do_reset();
    held = '0;
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (bus.col_sel_n !== 4'b0111) begin
      fails++;
      $display("FAIL walk_wrap got %b want 0111", bus.col_sel_n);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    held = 12'h008;
    frames(4);
    tests_run++;
    if (bus.keynote !== 10'b0000001000) begin
      fails++;
      $display("FAIL press_key3 got %b want 0000001000", bus.keynote);
    end
    held = '0;
    frames(4);
    tests_run++;
    if (bus.keynote !== 10'd0 || ev_seen !== 1) begin
      fails++;
      $display("FAIL release_key3 got key=%b events=%0d want 0/1", bus.keynote, ev_seen);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int f = 0; f < 8; f++) begin
      held = (f % 2 == 0) ? 12'h020 : 12'h000;
      frames(1);
    end
    tests_run++;
    if (bus.keynote !== 10'd0 || ev_seen !== 0) begin
      fails++;
      $display("FAIL bounce got key=%b events=%0d want 0/0", bus.keynote, ev_seen);
    end
    held = 12'h020;
    frames(4);
    tests_run++;
    if (bus.keynote !== 10'b0000100000) begin
      fails++;
      $display("FAIL bounce_settle got %b want 0000100000", bus.keynote);
    end
  endtask

  task automatic test_discarded();
    do_reset();
    held = 12'hC00;
    frames(5);
    tests_run++;
    if (bus.keynote !== 10'd0) begin
      fails++;
      $display("FAIL discard_10_11 got %b want 0", bus.keynote);
    end
    held = 12'h200;
    frames(4);
    tests_run++;
    if (bus.keynote !== 10'b1000000000) begin
      fails++;
      $display("FAIL key9 got %b want 1000000000", bus.keynote);
    end
  endtask

  task automatic test_multi_key();
    logic [9:0] want;
    int         want_ev;
`ifdef SINGLE_KEY_EN
    want = 10'b0000000001;
    want_ev = 0;
`else
    want = 10'b0010000001;
    want_ev = 1;
`endif
    do_reset();
    held = 12'h081;
    frames(4);
    tests_run++;
    if (bus.keynote !== want) begin
      fails++;
      $display("FAIL multi_0_7 got %b want %b", bus.keynote, want);
    end
    ev_seen = 0;
    held = 12'h091;
    frames(4);
    tests_run++;
    if (ev_seen !== want_ev) begin
      fails++;
      $display("FAIL add_key4_events got %0d want %0d", ev_seen, want_ev);
    end
  endtask

  task automatic test_random();
    do_reset();
    held = '0;
    for (int t = 0; t < 240; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        held = '0;
        for (int k = 0; k < int'($urandom_range(0, 3)); k++)
          held[$urandom_range(0, 11)] = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    held = '0;
    bus.scan_tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_column_walk();
    test_single_press();
    test_bounce();
    test_discarded();
    test_multi_key();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
